// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two memory requesters, the arbiter and the memory macro.
// slave = arbiter side; master = requesters plus memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_done;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_done;
  logic [DATA_W-1:0] m1_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_done, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_done, m1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_done, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_done, m1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the shared instruction/data memory: one transaction in flight,
// fixed MEM_LATENCY read return. Define ARB_ROUND_ROBIN_EN for round-robin contention.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              port_q;
  logic              we_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  logic              any_req;
  logic              win;
  logic              grant;
  logic              done;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q;
  // On contention the port that was not granted last wins.
  always_comb win = (bus.m0_req && bus.m1_req) ? ~last_q : bus.m1_req;
`else
  always_comb win = ~bus.m0_req;
`endif

  always_comb begin
    any_req   = bus.m0_req | bus.m1_req;
    grant     = (state == IDLE) && any_req && !reset;
    done      = (state == WAIT) && (cnt == '0) && !reset;
    win_we    = win ? bus.m1_we    : bus.m0_we;
    win_addr  = win ? bus.m1_addr  : bus.m0_addr;
    win_wdata = win ? bus.m1_wdata : bus.m0_wdata;
  end

  // Grant cycle: memory is driven straight from the winner's request fields.
  always_comb begin
    bus.m0_gnt    = grant && !win;
    bus.m1_gnt    = grant && win;
    bus.mem_en    = grant;
    bus.mem_we    = grant && win_we;
    bus.mem_addr  = grant ? win_addr  : '0;
    bus.mem_wdata = grant ? win_wdata : '0;
    bus.m0_done   = done && !port_q;
    bus.m1_done   = done && port_q;
    bus.m0_rdata  = (done && !port_q && !we_q) ? bus.mem_rdata : rdata0_q;
    bus.m1_rdata  = (done && port_q && !we_q)  ? bus.mem_rdata : rdata1_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q   <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state  <= WAIT;
            cnt    <= CNT_LOAD;
            port_q <= win;
            we_q   <= win_we;
`ifdef ARB_ROUND_ROBIN_EN
            last_q <= win;
`endif
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state <= IDLE;
            // Keep the returned word so mN_rdata holds across later writes.
            if (!we_q) begin
              if (port_q) rdata1_q <= bus.mem_rdata;
              else        rdata0_q <= bus.mem_rdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model of the arbitration and latency rules.
module tb_mem_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory macro stand-in with a LAT-deep read pipeline and a preload port.
  logic [DW-1:0] mem_arr [256];
  logic [DW-1:0] rd_pipe [LAT];
  logic          pre_en = 1'b0;
  logic [7:0]    pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_en) mem_arr[pre_addr] <= pre_data;
    else if (bus.mem_en && bus.mem_we) mem_arr[bus.mem_addr[7:0]] <= bus.mem_wdata;
    rd_pipe[0] <= (bus.mem_en && !bus.mem_we) ? mem_arr[bus.mem_addr[7:0]] : 32'hBADC_0DE0;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_rdata = rd_pipe[LAT-1];

  function automatic logic [5:0] ctl_bits();
    return {bus.m0_gnt, bus.m1_gnt, bus.m0_done, bus.m1_done, bus.mem_en, bus.mem_we};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic preload(input logic [7:0] a, input logic [DW-1:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_en = 1'b0;
  endtask

  task automatic test_reset();
    bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 32'h3; bus.m0_wdata = $urandom;
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h7; bus.m1_wdata = $urandom;
    @(negedge clk);
    n_tests++;
    if (ctl_bits() !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctl: got %b required 000000", ctl_bits());
    end
    n_tests++;
    if ({bus.mem_addr, bus.mem_wdata} !== 64'h0) begin
      n_fail++; $display("FAIL reset_membus: addr %h wdata %h required 0", bus.mem_addr, bus.mem_wdata);
    end
    n_tests++;
    if ({bus.m0_rdata, bus.m1_rdata} !== 64'h0) begin
      n_fail++; $display("FAIL reset_rdata: %h %h required 0", bus.m0_rdata, bus.m1_rdata);
    end
    tick();
    idle_inputs();
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (ctl_bits() !== 6'b0) begin
      n_fail++; $display("FAIL idle_no_req: got %b required 000000", ctl_bits());
    end
    tick();
  endtask

  task automatic test_single_read();
    int t0;
    preload(8'h10, 32'hDEADBEEF);
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h10; bus.m0_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    t0 = cyc;
    n_tests++;
    if (ctl_bits() !== 6'b100010) begin
      n_fail++; $display("FAIL rd_grant_ctl: got %b required 100010", ctl_bits());
    end
    n_tests++;
    if (bus.mem_addr !== 32'h10 || bus.mem_wdata !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL rd_grant_bus: addr %h wdata %h required 10 ffffffff", bus.mem_addr, bus.mem_wdata);
    end
    tick();
    bus.m0_req = 1'b0;
    for (int k = 1; k < LAT; k++) begin
      @(negedge clk);
      n_tests++;
      if (ctl_bits() !== 6'b0 || bus.mem_addr !== 32'h0) begin
        n_fail++; $display("FAIL rd_wait: ctl %b addr %h required 0", ctl_bits(), bus.mem_addr);
      end
      tick();
    end
    @(negedge clk);
    n_tests++;
    if (ctl_bits() !== 6'b001000) begin
      n_fail++; $display("FAIL rd_done_ctl: got %b required 001000", ctl_bits());
    end
    n_tests++;
    if (bus.m0_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL rd_data: got %h required deadbeef", bus.m0_rdata);
    end
    tick();
    bus.m0_req = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.m0_gnt !== 1'b1 || cyc - t0 != LAT + 1) begin
      n_fail++; $display("FAIL rd_next_grant: gnt %b after %0d cycles required 1 after %0d", bus.m0_gnt, cyc - t0, LAT + 1);
    end
    n_tests++;
    if (bus.m0_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL rd_hold: got %h required deadbeef", bus.m0_rdata);
    end
    tick();
    bus.m0_req = 1'b0;
    repeat (LAT) tick();
  endtask

  task automatic test_write_read();
    int tw;
    int tr;
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 32'h20; bus.m1_wdata = 32'h0000_1234;
    @(negedge clk);
    tw = cyc;
    n_tests++;
    if (ctl_bits() !== 6'b010011 || bus.mem_addr !== 32'h20 || bus.mem_wdata !== 32'h1234) begin
      n_fail++; $display("FAIL wr_grant: ctl %b addr %h wdata %h required 010011 20 1234", ctl_bits(), bus.mem_addr, bus.mem_wdata);
    end
    tick();
    bus.m1_req = 1'b0;
    for (int k = 0; k < 4 * LAT; k++) begin
      @(negedge clk);
      if (bus.m1_done === 1'b1) break;
      tick();
    end
    n_tests++;
    if (bus.m1_done !== 1'b1 || cyc - tw != LAT) begin
      n_fail++; $display("FAIL wr_done_latency: done %b after %0d cycles required 1 after %0d", bus.m1_done, cyc - tw, LAT);
    end
    n_tests++;
    if (bus.m1_rdata !== 32'h0) begin
      n_fail++; $display("FAIL wr_rdata_hold: got %h required 0", bus.m1_rdata);
    end
    tick();
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h20; bus.m1_wdata = 32'h0;
    @(negedge clk);
    tr = cyc;
    n_tests++;
    if (bus.m1_gnt !== 1'b1 || tr - tw != LAT + 1) begin
      n_fail++; $display("FAIL wr_rd_spacing: gnt %b spacing %0d required 1 spacing %0d", bus.m1_gnt, tr - tw, LAT + 1);
    end
    tick();
    bus.m1_req = 1'b0;
    for (int k = 0; k < 4 * LAT; k++) begin
      @(negedge clk);
      if (bus.m1_done === 1'b1) break;
      tick();
    end
    n_tests++;
    if (bus.m1_done !== 1'b1 || cyc - tr != LAT || bus.m1_rdata !== 32'h1234) begin
      n_fail++; $display("FAIL wr_rd_data: done %b lat %0d data %h required 1 %0d 00001234", bus.m1_done, cyc - tr, bus.m1_rdata, LAT);
    end
    tick();
  endtask

  task automatic test_req_during_wait();
    int t0;
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h3;
    @(negedge clk);
    t0 = cyc;
    n_tests++;
    if (bus.m0_gnt !== 1'b1) begin
      n_fail++; $display("FAIL wait_m0_grant: got %b required 1", bus.m0_gnt);
    end
    tick();
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h4;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      n_tests++;
      if (bus.m1_gnt !== 1'b0 || bus.m0_done !== (k == LAT)) begin
        n_fail++; $display("FAIL wait_no_gnt: cycle T+%0d m1_gnt %b m0_done %b required 0 %b", k, bus.m1_gnt, bus.m0_done, k == LAT);
      end
      tick();
    end
    @(negedge clk);
    n_tests++;
    if (bus.m1_gnt !== 1'b1 || cyc - t0 != LAT + 1) begin
      n_fail++; $display("FAIL wait_m1_grant: gnt %b at T+%0d required 1 at T+%0d", bus.m1_gnt, cyc - t0, LAT + 1);
    end
    tick();
    bus.m1_req = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      n_tests++;
      if (bus.m1_done !== (k == LAT)) begin
        n_fail++; $display("FAIL wait_m1_done: at T+%0d got %b required %b", LAT + 1 + k, bus.m1_done, k == LAT);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h5;
    @(negedge clk);
    n_tests++;
    if (bus.m0_gnt !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_grant: got %b required 1", bus.m0_gnt);
    end
    tick();
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 32'h9; bus.m1_wdata = 32'h5555_AAAA;
    reset = 1'b1;
    #1;
    n_tests++;
    if (ctl_bits() !== 6'b0 || {bus.mem_addr, bus.mem_wdata, bus.m0_rdata, bus.m1_rdata} !== 128'h0) begin
      n_fail++; $display("FAIL rstmid_outputs: ctl %b addr %h wdata %h rdata %h %h required 0", ctl_bits(), bus.mem_addr, bus.mem_wdata, bus.m0_rdata, bus.m1_rdata);
    end
    tick();
    tick();
    reset = 1'b0;
    bus.m1_req = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk);
      n_tests++;
      if ({bus.m0_done, bus.m1_done} !== 2'b00) begin
        n_fail++; $display("FAIL rstmid_no_done: got %b required 00", {bus.m0_done, bus.m1_done});
      end
      tick();
    end
    bus.m0_req = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.m0_gnt !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_regrant: got %b required 1", bus.m0_gnt);
    end
    tick();
    bus.m0_req = 1'b0;
    repeat (LAT) tick();
  endtask

  task automatic test_contention();
    logic [3:0] got;
    logic [3:0] exp_order;
    int ng;
    int tg;
    got = '0; ng = 0; tg = 0;
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = 4'b1010;
`else
    exp_order = 4'b0000;
`endif
    do_reset();
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h1;
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h2;
    for (int k = 0; k < 8 * (LAT + 1); k++) begin
      @(negedge clk);
      n_tests++;
      if (bus.m0_gnt === 1'b1 && bus.m1_gnt === 1'b1) begin
        n_fail++; $display("FAIL cont_onehot: both grants high");
      end
      if (bus.m0_gnt === 1'b1 || bus.m1_gnt === 1'b1) begin
        if (ng > 0) begin
          n_tests++;
          if (cyc - tg != LAT + 1) begin
            n_fail++; $display("FAIL cont_spacing: got %0d required %0d", cyc - tg, LAT + 1);
          end
        end
        got[ng] = bus.m1_gnt;
        tg = cyc;
        ng++;
      end
      if (ng == 4) break;
      tick();
    end
    n_tests++;
    if (ng != 4 || got !== exp_order) begin
      n_fail++; $display("FAIL cont_order: %0d grants, ports (bit0 first) %b required 4 grants %b", ng, got, exp_order);
    end
    tick();
    bus.m0_req = 1'b0;
    for (int k = 0; k < 4 * (LAT + 1); k++) begin
      @(negedge clk);
      if (bus.m1_gnt === 1'b1) break;
      tick();
    end
    n_tests++;
    if (bus.m1_gnt !== 1'b1 || cyc - tg != LAT + 1) begin
      n_fail++; $display("FAIL cont_loser_grant: gnt %b after %0d required 1 after %0d", bus.m1_gnt, cyc - tg, LAT + 1);
    end
    tick();
    bus.m1_req = 1'b0;
    repeat (LAT) tick();
  endtask

  task automatic test_random();
    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] last_rd [2];
    logic [DW-1:0] done_val;
    logic [AW-1:0] r_addr [2];
    logic [DW-1:0] r_wdata [2];
    logic          r_we [2];
    bit            pend [2];
    bit            w, eg0, eg1, ed0, ed1, done_port, done_rd;
    int            free_at, done_at;
`ifdef ARB_ROUND_ROBIN_EN
    bit            last_g;
    last_g = 1'b1;
`endif
    do_reset();
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      preload(8'(i), ref_mem[i]);
    end
    last_rd[0] = '0; last_rd[1] = '0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    free_at = cyc; done_at = -1; done_port = 1'b0; done_rd = 1'b0; done_val = '0; w = 1'b0;
    for (int p = 0; p < 2; p++) begin
      r_addr[p] = '0; r_wdata[p] = '0; r_we[p] = 1'b0;
    end
    for (int c = 0; c < 300; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && ($urandom % 3 != 0)) begin
          pend[p]    = 1'b1;
          r_we[p]    = 1'($urandom);
          r_addr[p]  = AW'($urandom % 16);
          r_wdata[p] = $urandom;
        end
      end
      bus.m0_req = pend[0]; bus.m0_we = r_we[0]; bus.m0_addr = r_addr[0]; bus.m0_wdata = r_wdata[0];
      bus.m1_req = pend[1]; bus.m1_we = r_we[1]; bus.m1_addr = r_addr[1]; bus.m1_wdata = r_wdata[1];
      @(negedge clk);
      eg0 = 1'b0; eg1 = 1'b0;
      if (cyc >= free_at && (pend[0] || pend[1])) begin
`ifdef ARB_ROUND_ROBIN_EN
        w = (pend[0] && pend[1]) ? !last_g : pend[1];
        last_g = w;
`else
        w = !pend[0];
`endif
        eg0 = !w; eg1 = w;
        free_at = cyc + LAT + 1;
        done_at = cyc + LAT;
        done_port = w;
        done_rd = !r_we[w];
        if (r_we[w]) ref_mem[r_addr[w][3:0]] = r_wdata[w];
        else         done_val = ref_mem[r_addr[w][3:0]];
      end
      ed0 = (cyc == done_at) && !done_port;
      ed1 = (cyc == done_at) && done_port;
      if ((ed0 || ed1) && done_rd) last_rd[done_port] = done_val;
      n_tests++;
      if ({bus.m0_gnt, bus.m1_gnt, bus.mem_en} !== {eg0, eg1, eg0 | eg1}) begin
        n_fail++; $display("FAIL rand_grant: cyc %0d gnt/en %b required %b", cyc, {bus.m0_gnt, bus.m1_gnt, bus.mem_en}, {eg0, eg1, eg0 | eg1});
      end
      n_tests++;
      if (eg0 || eg1) begin
        if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {r_we[w], r_addr[w], r_wdata[w]}) begin
          n_fail++; $display("FAIL rand_membus: cyc %0d we %b addr %h wdata %h required %b %h %h", cyc, bus.mem_we, bus.mem_addr, bus.mem_wdata, r_we[w], r_addr[w], r_wdata[w]);
        end
      end else if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== 65'h0) begin
        n_fail++; $display("FAIL rand_mem_idle: cyc %0d we %b addr %h wdata %h required 0", cyc, bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
      n_tests++;
      if ({bus.m0_done, bus.m1_done} !== {ed0, ed1}) begin
        n_fail++; $display("FAIL rand_done: cyc %0d got %b required %b", cyc, {bus.m0_done, bus.m1_done}, {ed0, ed1});
      end
      n_tests++;
      if (bus.m0_rdata !== last_rd[0] || bus.m1_rdata !== last_rd[1]) begin
        n_fail++; $display("FAIL rand_rdata: cyc %0d got %h %h required %h %h", cyc, bus.m0_rdata, bus.m1_rdata, last_rd[0], last_rd[1]);
      end
      if (bus.m0_gnt === 1'b1) pend[0] = 1'b0;
      if (bus.m1_gnt === 1'b1) pend[1] = 1'b0;
      tick();
    end
    idle_inputs();
    repeat (LAT + 1) tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    #1;
    reset = 1'b1;
    tick();
    test_reset();
    test_single_read();
    test_write_read();
    test_req_during_wait();
    test_reset_mid();
    test_contention();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
